pixel_compositor: RTL and testbench

Parametrised VGA pixel compositor that replaces the hard-coded sprite priority case in the game top level. It takes N sprite layers, each an enable plus RGB, selects the highest-priority enabled layer, falls back to a background colour, and applies blanking. It also owns a sticky game-status FSM (PLAY/LOSE/WIN) with a frame-counted red flash on loss. Sits between the sprite modules and the vgaR/vgaG/vgaB pins.

---
 rtl/pixel_compositor_if.sv | 44 ++++
 rtl/pixel_compositor.sv | 168 ++++++++++++++++
 tb/tb_pixel_compositor.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_compositor_if.sv
// Pixel compositor bus: sprite layers, blanking, game events in; pixel and status out.
//
// Handshake: this is a free-running pixel stream with no valid/ready pair.
// Every sys_clk cycle carries one pixel, the consumer can never stall it, and
// the result for a pixel appears a fixed two cycles after its inputs.
// frame_tick, lose_evt, win_evt and restart are sampled on every cycle.
interface pixel_compositor_if #(
    parameter int N_LAYERS = 12,
    parameter int RGB_W    = 12
);
    localparam int IDX_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

    // Pixel-side inputs
    logic                      bright;
    logic                      frame_tick;
    logic [N_LAYERS-1:0]       layer_en;
    logic [N_LAYERS*RGB_W-1:0] layer_rgb;
    logic [N_LAYERS-1:0]       layer_mask;

    // Game events
    logic                      lose_evt;
    logic                      win_evt;
    logic                      restart;

    // Results
    logic [RGB_W-1:0]          vga_rgb;
    logic [IDX_W-1:0]          hit_idx;
    logic                      hit_any;
    logic [1:0]                game_state;

    // Driver side: sprite modules and game logic
    modport master (
        output bright, frame_tick, layer_en, layer_rgb, layer_mask,
        output lose_evt, win_evt, restart,
        input  vga_rgb, hit_idx, hit_any, game_state
    );

    // Compositor side
    modport slave (
        input  bright, frame_tick, layer_en, layer_rgb, layer_mask,
        input  lose_evt, win_evt, restart,
        output vga_rgb, hit_idx, hit_any, game_state
    );
endinterface

// File: rtl/pixel_compositor.sv
// Pixel compositor: picks the highest-priority enabled sprite layer (index 0
// wins), falls back to a background colour, applies the game-status overlay
// and blanking, and drives a registered colour two cycles after its inputs.
// Also owns the sticky PLAY/LOSE/WIN state and the frame-counted loss flash.
module pixel_compositor #(
    parameter int               N_LAYERS     = 12,
    parameter int               RGB_W        = 12,
    parameter logic [RGB_W-1:0] BG_COLOR     = 12'h69C,
    parameter logic [RGB_W-1:0] LOSE_COLOR   = 12'hF00,
    parameter logic [RGB_W-1:0] WIN_COLOR    = 12'h0F0,
    parameter int               FLASH_FRAMES = 16
) (
    input  logic                sys_clk,
    input  logic                Reset,
    pixel_compositor_if.slave   bus
);
    localparam int IDX_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
    localparam int CNT_W = $clog2(FLASH_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_PLAY = 2'b00,
        ST_LOSE = 2'b01,
        ST_WIN  = 2'b10
    } game_state_t;

    // Game status FSM and loss-flash state
    game_state_t         r_state;
    logic [CNT_W-1:0]    r_flash_cnt;
    logic                r_flash_phase;

    // Stage 1: sprite selection result plus the bright flag that travels with it
    logic [IDX_W-1:0]    r_s1_idx;
    logic                r_s1_any;
    logic [RGB_W-1:0]    r_s1_rgb;
    logic                r_s1_bright;

    // Stage 2: output registers
    logic [RGB_W-1:0]    r_vga_rgb;
    logic [IDX_W-1:0]    r_hit_idx;
    logic                r_hit_any;

    // Combinational selection and overlay
    logic [N_LAYERS-1:0] w_eff_en;
    logic [IDX_W-1:0]    w_sel_idx;
    logic                w_sel_any;
    logic [RGB_W-1:0]    w_sel_rgb;
    logic [RGB_W-1:0]    w_s2_rgb;

    // A masked layer behaves exactly as if its sprite were off.
    assign w_eff_en = bus.layer_en & bus.layer_mask;

    // Priority select: scan from the lowest priority upward so the lowest
    // enabled index is the last to write and therefore wins. With no layer
    // enabled the index reads 0 and the colour is the background.
    always_comb begin
        w_sel_any = 1'b0;
        w_sel_idx = '0;
        w_sel_rgb = BG_COLOR;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (w_eff_en[i]) begin
                w_sel_any = 1'b1;
                w_sel_idx = IDX_W'(i);
                w_sel_rgb = bus.layer_rgb[i*RGB_W +: RGB_W];
            end
        end
    end

    // Stage 1 registers: sprite result and the bright flag for the same pixel
    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            r_s1_idx    <= '0;
            r_s1_any    <= 1'b0;
            r_s1_rgb    <= '0;
            r_s1_bright <= 1'b0;
        end else begin
            r_s1_idx    <= w_sel_idx;
            r_s1_any    <= w_sel_any;
            r_s1_rgb    <= w_sel_rgb;
            r_s1_bright <= bus.bright;
        end
    end

    // Overlay and blanking: blanking beats everything, then the game status
    // overlay, then the sprite/background colour. Uses the state register as
    // it stands when this pixel reaches stage 2.
    always_comb begin
        w_s2_rgb = r_s1_rgb;
        if (!r_s1_bright) begin
            w_s2_rgb = '0;
        end else if (r_state == ST_LOSE) begin
            w_s2_rgb = r_flash_phase ? '0 : LOSE_COLOR;
        end else if (r_state == ST_WIN) begin
            w_s2_rgb = WIN_COLOR;
        end
    end

    // Stage 2 registers: final pixel; hit info always reports the sprite result
    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            r_vga_rgb <= '0;
            r_hit_idx <= '0;
            r_hit_any <= 1'b0;
        end else begin
            r_vga_rgb <= w_s2_rgb;
            r_hit_idx <= r_s1_idx;
            r_hit_any <= r_s1_any;
        end
    end

    // Game status FSM with the loss flash counter. restart wins over events,
    // LOSE wins over WIN when both arrive together, and LOSE/WIN are sticky.
    // The counter and phase only move while in LOSE; a frame_tick on the
    // entry cycle is dropped because entry clears them.
    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            r_state       <= ST_PLAY;
            r_flash_cnt   <= '0;
            r_flash_phase <= 1'b0;
        end else begin
            case (r_state)
                ST_PLAY: begin
                    r_flash_cnt   <= '0;
                    r_flash_phase <= 1'b0;
                    if (bus.restart) begin
                        r_state <= ST_PLAY;
                    end else if (bus.lose_evt) begin
                        r_state <= ST_LOSE;
                    end else if (bus.win_evt) begin
                        r_state <= ST_WIN;
                    end
                end
                ST_LOSE: begin
                    if (bus.restart) begin
                        r_state       <= ST_PLAY;
                        r_flash_cnt   <= '0;
                        r_flash_phase <= 1'b0;
                    end else if (bus.frame_tick) begin
                        if (r_flash_cnt == CNT_LAST) begin
                            r_flash_cnt   <= '0;
                            r_flash_phase <= ~r_flash_phase;
                        end else begin
                            r_flash_cnt <= r_flash_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_WIN: begin
                    r_flash_cnt   <= '0;
                    r_flash_phase <= 1'b0;
                    if (bus.restart) begin
                        r_state <= ST_PLAY;
                    end
                end
                default: begin
                    r_state       <= ST_PLAY;
                    r_flash_cnt   <= '0;
                    r_flash_phase <= 1'b0;
                end
            endcase
        end
    end

    assign bus.vga_rgb    = r_vga_rgb;
    assign bus.hit_idx    = r_hit_idx;
    assign bus.hit_any    = r_hit_any;
    assign bus.game_state = r_state;

endmodule

// File: tb/tb_pixel_compositor.sv
// Bench for pixel_compositor: directed pixel vectors with hand-computed
// expected outputs, checked two cycles later by an independent monitor.
module tb_pixel_compositor;

    localparam int NL = 12;
    localparam int CW = 12;
    localparam int W  = CW + 4 + 1;

    localparam logic [3:0] EV_NONE = 4'b0000;
    localparam logic [3:0] EV_TICK = 4'b0001;
    localparam logic [3:0] EV_LOSE = 4'b0010;
    localparam logic [3:0] EV_WIN  = 4'b0100;
    localparam logic [3:0] EV_RST  = 4'b1000;

    logic           sys_clk;
    logic           Reset;
    logic           drv_valid;
    logic [1:0]     v_pipe;
    logic [CW-1:0]  lay_col [NL];
    logic [W-1:0]   exp_q [$];
    int             n_checks;
    int             n_errors;
    int             n_pix;

    pixel_compositor_if #(.N_LAYERS(NL), .RGB_W(CW)) pix ();

    pixel_compositor #(
        .N_LAYERS    (NL),
        .RGB_W       (CW),
        .FLASH_FRAMES(2)
    ) dut (
        .sys_clk(sys_clk),
        .Reset  (Reset),
        .bus    (pix)
    );

    // Clock and watchdog
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Two-cycle tag pipe marking which output cycles carry a driven vector
    always @(posedge sys_clk or posedge Reset) begin
        if (Reset) v_pipe <= 2'b00;
        else       v_pipe <= {v_pipe[0], drv_valid};
    end

    // Monitor: compare each tagged output pixel against the scoreboard head
    always @(negedge sys_clk) begin
        logic [W-1:0] e;
        logic [W-1:0] got;
        if (v_pipe[1] && !Reset) begin
            n_checks++;
            n_pix++;
            got = {pix.vga_rgb, pix.hit_idx, pix.hit_any};
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL pix%0d scoreboard empty, got rgb=%h idx=%0d any=%b",
                         n_pix, pix.vga_rgb, pix.hit_idx, pix.hit_any);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_errors++;
                    $display("FAIL pix%0d got rgb=%h idx=%0d any=%b want rgb=%h idx=%0d any=%b",
                             n_pix, pix.vga_rgb, pix.hit_idx, pix.hit_any,
                             e[W-1 -: CW], e[4:1], e[0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Apply one pixel vector now and queue its expected result
    task automatic apply(input logic br, input logic [NL-1:0] en, input logic [NL-1:0] msk,
                         input logic [3:0] ev, input logic [CW-1:0] e_rgb,
                         input logic [3:0] e_idx, input logic e_any);
        pix.bright     = br;
        pix.layer_en   = en;
        pix.layer_mask = msk;
        pix.frame_tick = ev[0];
        pix.lose_evt   = ev[1];
        pix.win_evt    = ev[2];
        pix.restart    = ev[3];
        for (int i = 0; i < NL; i++) pix.layer_rgb[i*CW +: CW] = lay_col[i];
        drv_valid = 1'b1;
        exp_q.push_back({e_rgb, e_idx, e_any});
    endtask

    task automatic drive(input logic br, input logic [NL-1:0] en, input logic [NL-1:0] msk,
                         input logic [3:0] ev, input logic [CW-1:0] e_rgb,
                         input logic [3:0] e_idx, input logic e_any);
        @(negedge sys_clk);
        apply(br, en, msk, ev, e_rgb, e_idx, e_any);
    endtask

    task automatic check_state(input logic [1:0] exp, input string name);
        @(negedge sys_clk);
        check(name, {30'd0, pix.game_state}, {30'd0, exp});
    endtask

    // Main sequence
    initial begin
        n_checks = 0;
        n_errors = 0;
        n_pix    = 0;
        drv_valid = 1'b0;
        Reset = 1'b1;
        pix.bright = 1'b0; pix.frame_tick = 1'b0;
        pix.layer_en = '0; pix.layer_mask = '0; pix.layer_rgb = '0;
        pix.lose_evt = 1'b0; pix.win_evt = 1'b0; pix.restart = 1'b0;
        for (int i = 0; i < NL; i++) lay_col[i] = 12'hA00 + CW'(i * 17);

        #3;
        check("rst_rgb",   {20'd0, pix.vga_rgb},  32'h0);
        check("rst_idx",   {28'd0, pix.hit_idx},  32'h0);
        check("rst_any",   {31'd0, pix.hit_any},  32'h0);
        check("rst_state", {30'd0, pix.game_state}, 32'h0);
        @(negedge sys_clk);
        Reset = 1'b0;

        // Priority: lowest enabled index wins, masking removes a layer
        lay_col[3] = 12'h123;
        lay_col[7] = 12'h456;
        drive(1, 12'h088, 12'hFFF, EV_NONE, 12'h123, 4'd3, 1);
        drive(1, 12'h088, 12'hFF7, EV_NONE, 12'h456, 4'd7, 1);
        // Background and blanking
        drive(1, 12'h000, 12'hFFF, EV_NONE, 12'h69C, 4'd0, 0);
        drive(0, 12'h001, 12'hFFF, EV_NONE, 12'h000, 4'd0, 1);
        // All layers on, partial/full masking, lowest priority alone
        drive(1, 12'hFFF, 12'hFFF, EV_NONE, 12'hA00, 4'd0, 1);
        drive(1, 12'hFFF, 12'hFFE, EV_NONE, 12'hA11, 4'd1, 1);
        drive(1, 12'hFFF, 12'h000, EV_NONE, 12'h69C, 4'd0, 0);
        drive(1, 12'h800, 12'hFFF, EV_NONE, 12'hABB, 4'd11, 1);

        // Back-to-back colour changes, no bubbles
        for (int k = 0; k < 8; k++) begin
            lay_col[0] = 12'h3C0 + CW'(k * 5);
            drive(1, 12'h001, 12'hFFF, EV_NONE, 12'h3C0 + CW'(k * 5), 4'd0, 1);
        end
        lay_col[0] = 12'hA00;

        // Loss with FLASH_FRAMES=2: phase flips every 2nd frame_tick
        drive(1, 12'h000, 12'hFFF, EV_LOSE, 12'hF00, 4'd0, 0);
        drive(1, 12'h001, 12'hFFF, EV_NONE, 12'hF00, 4'd0, 1);
        check("lose_state", {30'd0, pix.game_state}, 32'h1);
        drive(1, 12'h001, 12'hFFF, EV_TICK, 12'hF00, 4'd0, 1);
        drive(1, 12'h001, 12'hFFF, EV_TICK, 12'h000, 4'd0, 1);
        drive(1, 12'h002, 12'hFFF, EV_NONE, 12'h000, 4'd1, 1);
        drive(1, 12'h000, 12'hFFF, EV_TICK, 12'h000, 4'd0, 0);
        drive(1, 12'h000, 12'hFFF, EV_TICK, 12'hF00, 4'd0, 0);
        drive(1, 12'h000, 12'hFFF, EV_WIN,  12'hF00, 4'd0, 0);
        drive(1, 12'h000, 12'hFFF, EV_NONE, 12'hF00, 4'd0, 0);
        check("lose_sticky", {30'd0, pix.game_state}, 32'h1);
        drive(0, 12'h001, 12'hFFF, EV_NONE, 12'h000, 4'd0, 1);
        drive(1, 12'h000, 12'hFFF, EV_TICK, 12'hF00, 4'd0, 0);
        drive(1, 12'h000, 12'hFFF, EV_TICK, 12'h000, 4'd0, 0);

        // restart beats lose in the same cycle
        drive(1, 12'h001, 12'hFFF, EV_RST | EV_LOSE, 12'hA00, 4'd0, 1);
        drive(1, 12'h001, 12'hFFF, EV_NONE, 12'hA00, 4'd0, 1);
        check("restart_wins", {30'd0, pix.game_state}, 32'h0);

        // lose beats win; entry clears phase and swallows a same-cycle tick
        drive(1, 12'h001, 12'hFFF, EV_LOSE | EV_WIN | EV_TICK, 12'hF00, 4'd0, 1);
        drive(1, 12'h001, 12'hFFF, EV_NONE, 12'hF00, 4'd0, 1);
        check("lose_beats_win", {30'd0, pix.game_state}, 32'h1);
        drive(1, 12'h001, 12'hFFF, EV_TICK, 12'hF00, 4'd0, 1);
        drive(1, 12'h001, 12'hFFF, EV_TICK, 12'h000, 4'd0, 1);

        // Win, and no WIN to LOSE path
        drive(1, 12'h001, 12'hFFF, EV_RST, 12'hA00, 4'd0, 1);
        drive(1, 12'h004, 12'hFFF, EV_WIN, 12'h0F0, 4'd2, 1);
        drive(1, 12'h004, 12'hFFF, EV_NONE, 12'h0F0, 4'd2, 1);
        check("win_state", {30'd0, pix.game_state}, 32'h2);
        drive(1, 12'h000, 12'hFFF, EV_LOSE, 12'h0F0, 4'd0, 0);
        drive(1, 12'h001, 12'hFFF, EV_NONE, 12'h0F0, 4'd0, 1);
        check("win_sticky", {30'd0, pix.game_state}, 32'h2);

        // Asynchronous reset mid-stream while in WIN
        @(posedge sys_clk);
        #2;
        Reset = 1'b1;
        drv_valid = 1'b0;
        exp_q.delete();
        #1;
        check("arst_rgb",   {20'd0, pix.vga_rgb},    32'h0);
        check("arst_any",   {31'd0, pix.hit_any},    32'h0);
        check("arst_state", {30'd0, pix.game_state}, 32'h0);
        @(negedge sys_clk);
        Reset = 1'b0;
        apply(1, 12'h001, 12'hFFF, EV_NONE, 12'hA00, 4'd0, 1);
        @(negedge sys_clk);
        check("refill_empty", {20'd0, pix.vga_rgb}, 32'h0);
        apply(1, 12'h002, 12'hFFF, EV_NONE, 12'hA11, 4'd1, 1);

        // Drain
        @(negedge sys_clk);
        drv_valid = 1'b0;
        pix.layer_en = '0;
        pix.restart = 1'b0;
        repeat (4) @(negedge sys_clk);
        check("sb_drain", exp_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
